seg_display_driver: RTL and testbench

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

---
 rtl/seg_display_driver_pkg.sv | 28 ++
 rtl/seg_display_driver_bcd_to_seg7.sv | 27 ++
 rtl/seg_display_driver.sv | 121 ++++++++++++
 tb/tb_seg_display_driver.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_driver_pkg.sv
// Shared definitions for the 4-digit seven-segment display driver:
// conversion FSM encoding and active-low segment codes.
package seg_display_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // One double-dabble step per input bit of the 10-bit value.
    localparam int CONV_STEPS = 10;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_display_driver_bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decode;
// non-decimal nibbles light nothing.
module bcd_to_seg7
    import seg_display_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_driver.sv
// Converts a 10-bit value to BCD with a sequential double-dabble FSM and
// scans the four digits onto a multiplexed active-low display.
module seg_display_driver
    import seg_display_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] value,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       busy,
    output state_e     dbg_state
);

    localparam int             SCAN_W    = $clog2(REFRESH_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);
    localparam logic [3:0]     ITER_LAST = 4'(CONV_STEPS - 1);

    state_e              state, next_state;
    logic [9:0]          value_q, conv_src, bin_sr;
    logic [15:0]         bcd_sr, bcd_adj, digits_q;
    logic [3:0]          iter;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [1:0]          idx;
    logic [3:0]          cur_digit, lead_zero;
    logic [6:0]          dec_seg;
    logic                blank;

    assign dbg_state = state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (value_q != conv_src) next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (iter == ITER_LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Add-3 correction applied before every shift.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int n = 0; n < 4; n++) begin
            if (bcd_sr[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_sr[n*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            value_q  <= '0;
            conv_src <= '0;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            iter     <= '0;
            digits_q <= '0;
        end else begin
            state   <= next_state;
            busy    <= (next_state != IDLE);
            value_q <= value;
            case (state)
                LOAD: begin
                    conv_src <= value_q;
                    bin_sr   <= value_q;
                    bcd_sr   <= '0;
                    iter     <= '0;
                end
                SHIFT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    iter             <= iter + 4'd1;
                end
                DONE:    digits_q <= bcd_sr;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // A digit is a leading zero when it and every more-significant digit are 0.
    always_comb begin
        lead_zero[3] = (digits_q[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (digits_q[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (digits_q[7:4] == 4'd0);
        lead_zero[0] = 1'b0;
        cur_digit    = digits_q[{idx, 2'b00} +: 4];
        blank        = BLANK_LZ && lead_zero[idx];
    end

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an  <= 4'b1111;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= blank ? SEG_BLANK : dec_seg;
        end
    end

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver: two instances (blanking on/off)
// checked every cycle against a number-level model plus literal spot checks.
module tb_seg_display_driver;
    import seg_display_driver_pkg::*;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] value = '0;
    logic [3:0] an1, an0;
    logic [6:0] seg1, seg0;
    logic       busy1, busy0;
    state_e     st1, st0;

    int checks = 0;
    int passed = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    seg_display_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .value(value),
        .an(an1), .seg(seg1), .busy(busy1), .dbg_state(st1)
    );

    seg_display_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .value(value),
        .an(an0), .seg(seg0), .busy(busy0), .dbg_state(st0)
    );

    // ---------------- model ----------------
    logic [6:0] dec_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int         m_vq = 0, m_src = 0, m_disp = 0, m_cnt = 0, m_sc = 0, m_idx = 0;
    bit         m_busy = 1'b0;
    logic [3:0] m_an = 4'hF;
    logic [6:0] m_seg1 = 7'h7F, m_seg0 = 7'h7F;

    function automatic logic [6:0] exp_seg(input int n, input int k, input bit blank_lz);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (blank_lz && k > 0 && n < p) return 7'h7F;
        return dec_tab[(n / p) % 10];
    endfunction

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_vq = 0; m_src = 0; m_disp = 0; m_cnt = 0; m_sc = 0; m_idx = 0;
            m_busy = 1'b0; m_an = 4'hF; m_seg1 = 7'h7F; m_seg0 = 7'h7F;
        end else begin
            m_an   = ~(4'b0001 << m_idx);
            m_seg1 = exp_seg(m_disp, m_idx, 1'b1);
            m_seg0 = exp_seg(m_disp, m_idx, 1'b0);
            if (m_sc == DIV - 1) begin
                m_sc  = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_sc = m_sc + 1;
            end
            // A conversion takes 12 cycles and converts the value sampled on its first edge.
            if (!m_busy) begin
                if (m_vq != m_src) begin
                    m_busy = 1'b1;
                    m_cnt  = 12;
                end
            end else begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 11) m_src = m_vq;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    m_disp = m_src;
                end
            end
            m_vq = int'(value);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("an",        16'(an1),   16'(m_an));
            check("seg_blank", 16'(seg1),  16'(m_seg1));
            check("busy",      16'(busy1), 16'(m_busy));
            check("an_nb",     16'(an0),   16'(m_an));
            check("seg_nb",    16'(seg0),  16'(m_seg0));
            check("busy_nb",   16'(busy0), 16'(m_busy));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_an(input logic [3:0] pat);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an1 === pat) break;
        end
        check("wait_an", 16'(an1), 16'(pat));
    endtask

    task automatic wait_busy(input logic lvl, output int waited);
        waited = 0;
        while (busy1 !== lvl && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("wait_busy", 16'(busy1), 16'(lvl));
    endtask

    task automatic show(input logic [6:0] s3, input logic [6:0] s2,
                        input logic [6:0] s1, input logic [6:0] s0);
        wait_an(4'b0111); check("lit_d3", 16'(seg1), 16'(s3));
        wait_an(4'b1011); check("lit_d2", 16'(seg1), 16'(s2));
        wait_an(4'b1101); check("lit_d1", 16'(seg1), 16'(s1));
        wait_an(4'b1110); check("lit_d0", 16'(seg1), 16'(s0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w, len;
        cycles(1);
        cmp_en = 1'b1;
        cycles(2);
        check("rst_an",    16'(an1),   16'h000F);
        check("rst_seg",   16'(seg1),  16'h007F);
        check("rst_busy",  16'(busy1), 16'h0000);
        check("rst_state", 16'(st1),   16'(IDLE));
        reset_n = 1'b1;

        // value 0 after reset: only the ones digit lit, no conversion
        cycles(1);
        check("first_an",  16'(an1),  16'h000E);
        check("first_seg", 16'(seg1), 16'h0040);
        show(7'h7F, 7'h7F, 7'h7F, 7'h40);
        check("idle_busy", 16'(busy1), 16'h0000);

        // 1023: 12 busy cycles, all four digits lit
        value = 10'd1023;
        wait_busy(1'b1, w);
        len = 0;
        while (busy1 === 1'b1 && len < 40) begin
            @(negedge clk);
            len++;
        end
        check("busy_len", 16'(len), 16'd12);
        show(7'h79, 7'h40, 7'h24, 7'h30);

        // 5 then 999 mid-conversion
        value = 10'd5;
        wait_busy(1'b1, w);
        cycles(3);
        value = 10'd999;
        wait_busy(1'b0, w);
        len = 0;
        while (busy1 !== 1'b1 && len < 10) begin
            @(negedge clk);
            len++;
        end
        check("reassert", 16'(len >= 1 && len <= 2), 16'd1);
        wait_busy(1'b0, w);
        show(7'h7F, 7'h10, 7'h10, 7'h10);
        wait_an(4'b0111);
        check("nb_999_d3", 16'(seg0), 16'h0040);

        // 100: interior zeros stay lit
        value = 10'd100;
        wait_busy(1'b1, w);
        wait_busy(1'b0, w);
        show(7'h7F, 7'h79, 7'h40, 7'h40);
        wait_an(4'b0111);
        check("nb_100_d3", 16'(seg0), 16'h0040);

        // scan wrap 3 -> 0 takes exactly DIV cycles
        len = 0;
        while (an1 === 4'b0111 && len < 20) begin
            @(negedge clk);
            len++;
        end
        check("wrap_an", 16'(an1), 16'h000E);
        wait_an(4'b0111);
        len = 0;
        while (an1 !== 4'b1110 && len < 20) begin
            @(negedge clk);
            len++;
        end
        check("wrap_len", 16'(len), 16'(DIV));

        // reset during the 5th SHIFT cycle
        value = 10'd777;
        wait_busy(1'b1, w);
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_an",    16'(an1),   16'h000F);
        check("mid_seg",   16'(seg1),  16'h007F);
        check("mid_busy",  16'(busy1), 16'h0000);
        check("mid_state", 16'(st1),   16'(IDLE));
        @(negedge clk);
        value = 10'd0;
        cycles(2);
        reset_n = 1'b1;
        cycles(20);
        check("post_busy", 16'(busy1), 16'h0000);
        show(7'h7F, 7'h7F, 7'h7F, 7'h40);

        cycles(2);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
